// File: rtl/axi4lite_apb_master.sv
// AXI4-Lite slave side to APB4 master bridge: one-deep AW/W/AR holding registers,
// round-robin write/read arbitration, one APB transfer in flight at a time.
module axi4lite_apb_master #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRWIDTH-1:0]   awaddr,
    input  logic [2:0]             awprot,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATAWIDTH-1:0]   wdata,
    input  logic [DATAWIDTH/8-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ADDRWIDTH-1:0]   araddr,
    input  logic [2:0]             arprot,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [DATAWIDTH-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [ADDRWIDTH-1:0]   paddr,
    output logic [2:0]             pprot,
    output logic                   pwrite,
    output logic                   psel,
    output logic                   penable,
    output logic [DATAWIDTH-1:0]   pwdata,
    output logic [DATAWIDTH/8-1:0] pstrb,
    input  logic [DATAWIDTH-1:0]   prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int unsigned StrbWidth = DATAWIDTH / 8;

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StWresp, StRresp} state_e;

    state_e               state;
    logic                 aw_full, w_full, ar_full, wr_last;
    logic                 aw_full_d, w_full_d, ar_full_d;
    logic                 aw_hs, w_hs, ar_hs, done_wr, done_rd;
    logic                 wr_req, rd_req, grant_wr;
    logic [ADDRWIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [2:0]           aw_prot_q, ar_prot_q;
    logic [DATAWIDTH-1:0] w_data_q;
    logic [StrbWidth-1:0] w_strb_q;

    always_comb begin
        aw_hs    = awvalid & awready;
        w_hs     = wvalid & wready;
        ar_hs    = arvalid & arready;
        done_wr  = (state == StAccess) & pready & pwrite;
        done_rd  = (state == StAccess) & pready & ~pwrite;
        wr_req   = aw_full & w_full;
        rd_req   = ar_full;
        grant_wr = wr_req & (~rd_req | ~wr_last);

        // A slot is never both accepting and completing: ready is low while full.
        aw_full_d = aw_full;
        w_full_d  = w_full;
        ar_full_d = ar_full;
        if (done_wr) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (done_rd) ar_full_d = 1'b0;
        if (aw_hs)   aw_full_d = 1'b1;
        if (w_hs)    w_full_d  = 1'b1;
        if (ar_hs)   ar_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            wr_last   <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            arready   <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= 2'b00;
            bvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= 2'b00;
            rvalid    <= 1'b0;
            paddr     <= '0;
            pprot     <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            aw_full <= aw_full_d;
            w_full  <= w_full_d;
            ar_full <= ar_full_d;
            awready <= ~aw_full_d;
            wready  <= ~w_full_d;
            arready <= ~ar_full_d;

            if (aw_hs) begin
                aw_addr_q <= awaddr;
                aw_prot_q <= awprot;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (ar_hs) begin
                ar_addr_q <= araddr;
                ar_prot_q <= arprot;
            end

            case (state)
                StIdle: begin
                    if (grant_wr) begin
                        paddr  <= aw_addr_q;
                        pprot  <= aw_prot_q;
                        pwrite <= 1'b1;
                        pwdata <= w_data_q;
                        pstrb  <= w_strb_q;
                        psel   <= 1'b1;
                        state  <= StSetup;
                    end else if (rd_req) begin
                        // pwdata deliberately keeps its previous value on reads.
                        paddr  <= ar_addr_q;
                        pprot  <= ar_prot_q;
                        pwrite <= 1'b0;
                        pstrb  <= '0;
                        psel   <= 1'b1;
                        state  <= StSetup;
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pwrite) begin
                            bresp  <= pslverr ? 2'b10 : 2'b00;
                            bvalid <= 1'b1;
                            state  <= StWresp;
                        end else begin
                            rdata  <= prdata;
                            rresp  <= pslverr ? 2'b10 : 2'b00;
                            rvalid <= 1'b1;
                            state  <= StRresp;
                        end
                    end
                end
                StWresp: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        wr_last <= 1'b1;
                        state   <= StIdle;
                    end
                end
                StRresp: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        wr_last <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_apb_master.sv
// Scoreboard bench for axi4lite_apb_master: directed AXI stimulus, APB slave model,
// expected APB/B/R beats queued at issue time and checked by a separate monitor.
module tb_axi4lite_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata, prdata;
    logic [2:0]  awprot, arprot, pprot;
    logic [3:0]  wstrb, pstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        pwrite, psel, penable, pready, pslverr;

    always #5 clk = ~clk;

    axi4lite_apb_master #(.DATAWIDTH(32), .ADDRWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct packed {
        logic        wr;
        logic [2:0]  prot;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } apb_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_t;

    apb_t        apb_q[$];
    logic [1:0]  b_q[$];
    r_t          r_q[$];
    apb_t        exp_apb;
    r_t          exp_r;
    logic [1:0]  exp_b;

    int          checks = 0;
    int          errors = 0;

    int          slv_wait = 0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // APB slave: completes an ACCESS after slv_wait wait states.
    initial begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        acc_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) begin
                pready  = (acc_cnt >= slv_wait);
                pslverr = pready && slv_err;
                prdata  = pready ? slv_rdata : '0;
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '0;
                acc_cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat.
    always @(negedge clk) begin
        if (rst) begin
            if (psel && penable && pready) begin
                if (apb_q.size() == 0) fail("apb_unexpected_transfer");
                else begin
                    exp_apb = apb_q.pop_front();
                    check("apb_ctrl_addr", {pwrite, pprot, paddr},
                          {exp_apb.wr, exp_apb.prot, exp_apb.addr});
                    check("apb_data_strb", {pwdata, pstrb}, {exp_apb.data, exp_apb.strb});
                end
            end
            if (bvalid && bready) begin
                if (b_q.size() == 0) fail("b_unexpected_beat");
                else begin
                    exp_b = b_q.pop_front();
                    check("b_resp", bresp, exp_b);
                end
            end
            if (rvalid && rready) begin
                if (r_q.size() == 0) fail("r_unexpected_beat");
                else begin
                    exp_r = r_q.pop_front();
                    check("r_beat", {rdata, rresp}, {exp_r.data, exp_r.resp});
                end
            end
            if (penable && !psel) fail("penable_without_psel");
        end
    end

    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [31:0] aaddr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] raddr);
        int n = 0;
        bit hs_aw, hs_w, hs_ar;
        awaddr  = aaddr;
        awprot  = 3'b010;
        wdata   = wd;
        wstrb   = ws;
        araddr  = raddr;
        arprot  = 3'b001;
        awvalid = do_aw;
        wvalid  = do_w;
        arvalid = do_ar;
        while ((awvalid || wvalid || arvalid) && n < 50) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_ar = arvalid && arready;
            @(posedge clk);
            #1;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            if (hs_ar) arvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid || arvalid) begin
            fail("issue_handshake_timeout");
            awvalid = 1'b0;
            wvalid  = 1'b0;
            arvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((apb_q.size() != 0 || b_q.size() != 0 || r_q.size() != 0 || psel || bvalid
                || rvalid) && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) fail("drain_timeout");
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        rst     = 1'b0;
        awaddr  = '0; awprot = '0; awvalid = 1'b0;
        wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
        araddr  = '0; arprot = '0; arvalid = 1'b0;
        bready  = 1'b1;
        rready  = 1'b1;

        #2;
        check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, psel, penable, pwrite,
                             bresp, rresp, pprot}, 0);
        check("reset_bus_a", {paddr, pwdata}, 0);
        check("reset_bus_b", {rdata, pstrb}, 0);
        step(2);
        rst = 1'b1;
        step(2);
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        // Simple write, AW and W together: latency check.
        apb_q.push_back('{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 4'hF});
        b_q.push_back(2'b00);
        issue(1, 1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
        @(negedge clk); check("t1_idle_after_hs", {psel, penable}, 2'b00);
        @(negedge clk); check("t1_setup", {psel, penable}, 2'b10);
        @(negedge clk); check("t1_access", {psel, penable, pwrite, paddr}, {3'b111, 32'h10});
        @(negedge clk); check("t1_bvalid", {bvalid, bresp, psel}, {1'b1, 2'b00, 1'b0});
        @(posedge clk); #1;
        drain();

        // Read with three wait states.
        slv_wait  = 3;
        slv_rdata = 32'h1234_5678;
        apb_q.push_back('{1'b0, 3'b001, 32'h20, 32'hDEAD_BEEF, 4'h0});
        r_q.push_back('{32'h1234_5678, 2'b00});
        issue(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h20);
        cnt = 0;
        n   = 0;
        do begin
            @(negedge clk);
            if (penable) cnt++;
            n++;
        end while (!rvalid && n < 40);
        check("t2_penable_cycles", cnt, 4);
        check("t2_pstrb_zero", pstrb, 4'h0);
        @(posedge clk); #1;
        drain();
        slv_wait = 0;

        // Slave error with B backpressure.
        bready  = 1'b0;
        slv_err = 1'b1;
        apb_q.push_back('{1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 4'h3});
        b_q.push_back(2'b10);
        issue(1, 1, 0, 32'h30, 32'hCAFE_F00D, 4'h3, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bvalid && n < 40);
        cnt = 0;
        repeat (5) begin
            if (bvalid && bresp == 2'b10) cnt++;
            @(negedge clk);
        end
        check("t3_bvalid_stable", cnt, 5);
        @(posedge clk); #1;
        bready  = 1'b1;
        slv_err = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_single_beat", bvalid, 1'b0);
        @(posedge clk); #1;
        drain();

        // W arrives before AW.
        apb_q.push_back('{1'b1, 3'b010, 32'h40, 32'h1122_3344, 4'hF});
        b_q.push_back(2'b00);
        issue(0, 1, 0, 32'h0, 32'h1122_3344, 4'hF, 32'h0);
        @(negedge clk); check("t4_wready_low", wready, 1'b0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (psel || penable) cnt++;
        end
        check("t4_no_apb_before_aw", cnt, 0);
        @(posedge clk); #1;
        issue(1, 0, 0, 32'h40, 32'h1122_3344, 4'hF, 32'h0);
        drain();
        check("t4_wready_back", wready, 1'b1);

        // Arbitration after a fresh reset: W,R then W,R, then read wins after a write.
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        slv_rdata = 32'h0BAD_F00D;
        apb_q.push_back('{1'b1, 3'b010, 32'h50, 32'hA5A5_A5A5, 4'hF});
        apb_q.push_back('{1'b0, 3'b001, 32'h60, 32'hA5A5_A5A5, 4'h0});
        b_q.push_back(2'b00);
        r_q.push_back('{32'h0BAD_F00D, 2'b00});
        issue(1, 1, 1, 32'h50, 32'hA5A5_A5A5, 4'hF, 32'h60);
        drain();
        apb_q.push_back('{1'b1, 3'b010, 32'h54, 32'h5A5A_5A5A, 4'hC});
        apb_q.push_back('{1'b0, 3'b001, 32'h64, 32'h5A5A_5A5A, 4'h0});
        b_q.push_back(2'b00);
        r_q.push_back('{32'h0BAD_F00D, 2'b00});
        issue(1, 1, 1, 32'h54, 32'h5A5A_5A5A, 4'hC, 32'h64);
        drain();
        apb_q.push_back('{1'b1, 3'b010, 32'h58, 32'h0102_0304, 4'hF});
        b_q.push_back(2'b00);
        issue(1, 1, 0, 32'h58, 32'h0102_0304, 4'hF, 32'h0);
        drain();
        apb_q.push_back('{1'b0, 3'b001, 32'h68, 32'h0102_0304, 4'h0});
        apb_q.push_back('{1'b1, 3'b010, 32'h5C, 32'h0F0E_0D0C, 4'h1});
        r_q.push_back('{32'h0BAD_F00D, 2'b00});
        b_q.push_back(2'b00);
        issue(1, 1, 1, 32'h5C, 32'h0F0E_0D0C, 4'h1, 32'h68);
        drain();

        // Reset while stalled in ACCESS: the aborted write never responds.
        slv_wait = 100;
        issue(1, 1, 0, 32'h70, 32'h7777_7777, 4'hF, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(psel && penable) && n < 20);
        check("t6_reached_access", {psel, penable}, 2'b11);
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_clear", {psel, penable, bvalid, rvalid, awready, wready, arready}, 0);
        @(negedge clk);
        rst      = 1'b1;
        slv_wait = 0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (psel || penable || bvalid || rvalid) cnt++;
        end
        check("t6_no_response_after_abort", cnt, 0);
        check("t6_ready_after_abort", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;

        // Recovery read; pwdata was cleared by the reset.
        slv_rdata = 32'hFEED_FACE;
        apb_q.push_back('{1'b0, 3'b001, 32'h80, 32'h0, 4'h0});
        r_q.push_back('{32'hFEED_FACE, 2'b00});
        issue(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h80);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
